frame_cmd_sequencer: RTL

- Sits between the controller UART receiver and the framebuffer RAM inside main.
- Parses the received byte stream into display commands and sequences the RAM writes.
  - 'L' row load: 0x4C, row byte, 128 pixel bytes.
  - 'b' brightness: 0x62, value byte.
  - 'R' soft reset: 0x52.
- Reports row completion to the scan/refresh logic and aborts malformed or stalled commands.

---
 rtl/frame_cmd_pkg.sv | 23 ++
 rtl/inter_byte_timer.sv | 28 ++
 rtl/frame_cmd_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/frame_cmd_pkg.sv
// rtl/frame_cmd_pkg.sv - shared command bytes, sequencer states and row sizing for frame_cmd_sequencer
package frame_cmd_pkg;

    localparam logic [7:0] CMD_ROW    = 8'h4C;
    localparam logic [7:0] CMD_BRIGHT = 8'h62;
    localparam logic [7:0] CMD_RESET  = 8'h52;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_ADDR = 2'd1,
        PIXELS   = 2'd2,
        BRIGHT   = 2'd3
    } state_t;

    localparam int DEFAULT_PIXELS_PER_ROW  = 64;
    localparam int DEFAULT_BYTES_PER_PIXEL = 2;
    localparam int ROW_BYTES = DEFAULT_PIXELS_PER_ROW * DEFAULT_BYTES_PER_PIXEL;

    function automatic int row_bytes(input int pixels_per_row, input int bytes_per_pixel);
        return pixels_per_row * bytes_per_pixel;
    endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// rtl/inter_byte_timer.sv - inter-byte stall counter; built only when FRAME_CMD_TIMEOUT_EN is defined
module inter_byte_timer #(
    parameter int TICKS = 1000,
    parameter int WIDTH = 10
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] count;

    // A byte arriving in the expiry cycle wins, so clear masks expire.
    assign expire = enable && !clear && (count == WIDTH'(TICKS - 1));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_cmd_sequencer.sv
// rtl/frame_cmd_sequencer.sv - UART byte stream to framebuffer write sequencer
// Optional inter-byte timeout abort enabled by defining FRAME_CMD_TIMEOUT_EN.
module frame_cmd_sequencer
    import frame_cmd_pkg::*;
#(
    parameter int PIXELS_PER_ROW      = 64,
    parameter int BYTES_PER_PIXEL     = 2,
    parameter int ROW_ADDR_WIDTH      = 5,
    parameter int TIMEOUT_TICKS       = 1000,
    parameter int TIMEOUT_TICKS_WIDTH = 10
) (
    input  logic                        clk_in,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        ram_write_enable,
    output logic [ROW_ADDR_WIDTH+6:0]   ram_address,
    output logic [7:0]                  ram_data,
    output logic                        row_done,
    output logic [ROW_ADDR_WIDTH-1:0]   row_done_index,
    output logic [7:0]                  brightness,
    output logic                        soft_reset_pulse,
    output logic                        cmd_busy,
    output logic                        cmd_error
);

    localparam int         ROW_BYTES_CFG = row_bytes(PIXELS_PER_ROW, BYTES_PER_PIXEL);
    localparam logic [6:0] LAST_BYTE     = 7'(ROW_BYTES_CFG - 1);

    state_t                    state;
    logic [ROW_ADDR_WIDTH-1:0] row;
    logic [6:0]                byte_cnt;
    logic                      timeout;
    logic                      row_ok;

    assign row_ok = ((rx_data >> ROW_ADDR_WIDTH) == 8'd0);

`ifdef FRAME_CMD_TIMEOUT_EN
    inter_byte_timer #(
        .TICKS (TIMEOUT_TICKS),
        .WIDTH (TIMEOUT_TICKS_WIDTH)
    ) u_timer (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clear   (rx_valid),
        .enable  (cmd_busy),
        .expire  (timeout)
    );
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_TICKS + TIMEOUT_TICKS_WIDTH;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            row              <= '0;
            byte_cnt         <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data         <= 8'h00;
            row_done         <= 1'b0;
            row_done_index   <= '0;
            brightness       <= 8'hFF;
            soft_reset_pulse <= 1'b0;
            cmd_busy         <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            row_done         <= 1'b0;
            soft_reset_pulse <= 1'b0;
            cmd_error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_ROW: begin
                                state    <= ROW_ADDR;
                                cmd_busy <= 1'b1;
                            end
                            CMD_BRIGHT: begin
                                state    <= BRIGHT;
                                cmd_busy <= 1'b1;
                            end
                            CMD_RESET: soft_reset_pulse <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ROW_ADDR: begin
                    if (rx_valid) begin
                        if (row_ok) begin
                            row      <= rx_data[ROW_ADDR_WIDTH-1:0];
                            byte_cnt <= '0;
                            state    <= PIXELS;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= IDLE;
                            cmd_busy  <= 1'b0;
                        end
                    end else if (timeout) begin
                        cmd_error <= 1'b1;
                        state     <= IDLE;
                        cmd_busy  <= 1'b0;
                    end
                end
                PIXELS: begin
                    // Payload bytes go straight to RAM; command codes are not decoded here.
                    if (rx_valid) begin
                        ram_write_enable <= 1'b1;
                        ram_address      <= {row, byte_cnt};
                        ram_data         <= rx_data;
                        byte_cnt         <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            row_done       <= 1'b1;
                            row_done_index <= row;
                            state          <= IDLE;
                            cmd_busy       <= 1'b0;
                        end
                    end else if (timeout) begin
                        cmd_error <= 1'b1;
                        state     <= IDLE;
                        cmd_busy  <= 1'b0;
                    end
                end
                BRIGHT: begin
                    if (rx_valid) begin
                        brightness <= rx_data;
                        state      <= IDLE;
                        cmd_busy   <= 1'b0;
                    end else if (timeout) begin
                        cmd_error <= 1'b1;
                        state     <= IDLE;
                        cmd_busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cmd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
